// File: rtl/drop_token_pkg.sv
// Shared Score 4 board types: geometry, cell encoding and the panel layout
// used by the move engine and the win checker.
package drop_token_pkg;

  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P0    = 2'b01,
    P1    = 2'b10
  } cell_t;

  // panel[col][row], row 0 is the bottom of the board
  typedef cell_t [COLS-1:0][ROWS-1:0] panel_t;

  function automatic cell_t turn_cell(input logic turn);
    return turn ? P1 : P0;
  endfunction

endpackage

// File: rtl/drop_token.sv
// Score 4 move engine: owns the board, animates a falling token one row per
// cycle, commits it and passes the turn to the other player.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a column request; rejects full/out-of-range ones
// S_FALL   | token dropping one row per cycle until it rests
// S_COMMIT | token written into the panel, turn toggled, move_done set
module drop_token
  import drop_token_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  output logic       move_ready,
  input  logic       game_over,
  output panel_t     panel,
  output logic       turn,
  output logic       fall_valid,
  output logic [2:0] fall_col,
  output logic [2:0] fall_row,
  output logic       move_done,
  output logic       move_illegal,
  output logic       board_full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FALL,
    S_COMMIT
  } state_t;

  state_t     state;
  logic [5:0] move_count;
  logic       col_oob;
  logic       col_full;
  logic       landed;

  assign col_oob    = move_col >= 3'(COLS);
  assign board_full = move_count == 6'(CELLS);
  assign move_ready = (state == S_IDLE) && !game_over && !board_full;

  // Guard the top-row lookup so an out-of-range column never indexes the panel
  always_comb begin
    col_full = 1'b0;
    if (!col_oob)
      col_full = panel[move_col][ROWS-1] != EMPTY;
  end

  always_comb begin
    landed = 1'b1;
    if (fall_row != 3'd0)
      landed = panel[fall_col][fall_row - 3'd1] != EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      panel        <= '{default: EMPTY};
      turn         <= 1'b0;
      move_count   <= 6'd0;
      fall_valid   <= 1'b0;
      fall_col     <= 3'd0;
      fall_row     <= 3'd0;
      move_done    <= 1'b0;
      move_illegal <= 1'b0;
    end else if (new_game) begin
      state        <= S_IDLE;
      panel        <= '{default: EMPTY};
      turn         <= 1'b0;
      move_count   <= 6'd0;
      fall_valid   <= 1'b0;
      fall_col     <= 3'd0;
      fall_row     <= 3'd0;
      move_done    <= 1'b0;
      move_illegal <= 1'b0;
    end else begin
      move_done    <= 1'b0;
      move_illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (move_valid && move_ready) begin
            if (col_oob || col_full) begin
              move_illegal <= 1'b1;
            end else begin
              fall_col   <= move_col;
              fall_row   <= 3'(ROWS - 1);
              fall_valid <= 1'b1;
              state      <= S_FALL;
            end
          end
        end
        S_FALL: begin
          if (landed)
            state <= S_COMMIT;
          else
            fall_row <= fall_row - 3'd1;
        end
        S_COMMIT: begin
          panel[fall_col][fall_row] <= turn_cell(turn);
          turn       <= ~turn;
          move_count <= move_count + 6'd1;
          move_done  <= 1'b1;
          fall_valid <= 1'b0;
          fall_col   <= 3'd0;
          fall_row   <= 3'd0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drop_token.sv
// Self-checking bench for drop_token: directed scenarios plus random column
// requests compared against a column-height board model.
module tb_drop_token;
  import drop_token_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [2:0] move_col = 3'd0;
  logic       game_over = 1'b0;
  logic       move_ready;
  panel_t     panel;
  logic       turn;
  logic       fall_valid;
  logic [2:0] fall_col;
  logic [2:0] fall_row;
  logic       move_done;
  logic       move_illegal;
  logic       board_full;

  logic [COLS*ROWS*2-1:0] panel_flat;
  assign panel_flat = panel;

  drop_token dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_game     (new_game),
    .move_valid   (move_valid),
    .move_col     (move_col),
    .move_ready   (move_ready),
    .game_over    (game_over),
    .panel        (panel),
    .turn         (turn),
    .fall_valid   (fall_valid),
    .fall_col     (fall_col),
    .fall_row     (fall_row),
    .move_done    (move_done),
    .move_illegal (move_illegal),
    .board_full   (board_full)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: per-column stack heights and the owner of every cell
  int         height [COLS];
  logic [1:0] board  [COLS][ROWS];
  logic       m_turn;
  int         m_count;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COLS*ROWS*2-1:0] model_panel();
    logic [COLS*ROWS*2-1:0] p;
    p = '0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        p[(c*ROWS + r)*2 +: 2] = board[c][r];
    return p;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < COLS; c++) begin
      height[c] = 0;
      for (int r = 0; r < ROWS; r++) board[c][r] = 2'b00;
    end
    m_turn  = 1'b0;
    m_count = 0;
  endtask

  task automatic start_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_clear();
    check("newgame_panel", panel_flat, '0);
    check("newgame_turn", turn, 1'b0);
  endtask

  task automatic do_move(input int c, input bit raise_go);
    bit legal;
    bit bad;
    int r;
    int k;
    int exp_row;
    legal = (c < COLS) && (height[c] < ROWS);
    @(negedge clk);
    move_valid = 1'b1;
    move_col   = 3'(c);
    @(posedge clk); #1;
    move_valid = 1'b0;
    if (!legal) begin
      check("illegal_pulse", {move_illegal, fall_valid, move_done}, 3'b100);
      @(posedge clk); #1;
      check("illegal_drop", move_illegal, 1'b0);
      check("illegal_panel", panel_flat, model_panel());
      check("illegal_turn", turn, m_turn);
      return;
    end
    r = height[c];
    check("accept", {fall_valid, fall_col, fall_row, move_ready}, {1'b1, 3'(c), 3'(ROWS-1), 1'b0});
    if (raise_go) game_over = 1'b1;
    bad = 1'b0;
    k = 0;
    while (!move_done && k < 20) begin
      exp_row = (ROWS - 1 - k > r) ? ROWS - 1 - k : r;
      if (!fall_valid || move_illegal || fall_row != 3'(exp_row) || fall_col != 3'(c))
        bad = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    check("fall_trace_bad", bad, 1'b0);
    check("done_latency", k, ROWS - r + 1);
    board[c][r] = m_turn ? 2'b10 : 2'b01;
    height[c]++;
    m_turn = ~m_turn;
    m_count++;
    check("done_panel", panel_flat, model_panel());
    check("done_turn", {turn, move_illegal, fall_valid}, {m_turn, 2'b00});
    check("board_full", board_full, m_count == CELLS);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {turn, fall_valid, fall_col, fall_row, move_done, move_illegal, board_full},
          '0);
    check("reset_panel", panel_flat, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_ready", move_ready, 1'b1);

    // two tokens stacked in column 3
    do_move(3, 0);
    check("first_cell", panel[3][0], 2'b01);
    @(posedge clk); #1;
    check("done_one_cycle", move_done, 1'b0);
    do_move(3, 0);
    check("second_cell", panel[3][1], 2'b10);

    // fill column 0, then full-column and out-of-range requests
    for (int i = 0; i < ROWS; i++) do_move(0, 0);
    do_move(0, 0);
    check("ready_after_illegal", move_ready, 1'b1);
    do_move(7, 0);

    // game_over in IDLE blocks requests
    game_over = 1'b1;
    #1;
    check("go_ready", move_ready, 1'b0);
    @(negedge clk);
    move_valid = 1'b1;
    move_col   = 3'd1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    check("go_ignored", {fall_valid, move_illegal}, 2'b00);
    @(posedge clk); #1;
    check("go_panel", panel_flat, model_panel());
    game_over = 1'b0;

    // game_over raised mid-fall: move completes, then ready stays low
    do_move(5, 1);
    check("go_after_move", move_ready, 1'b0);
    game_over = 1'b0;

    // new_game during FALL aborts with no move_done
    @(negedge clk);
    move_valid = 1'b1;
    move_col   = 3'd4;
    @(posedge clk); #1;
    move_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    new_game   = 1'b1;
    move_valid = 1'b1;
    @(posedge clk); #1;
    new_game   = 1'b0;
    move_valid = 1'b0;
    model_clear();
    check("abort_state", {turn, fall_valid, move_done, move_illegal}, 4'b0000);
    check("abort_panel", panel_flat, '0);
    repeat (8) begin
      @(posedge clk); #1;
      if (move_done || fall_valid) check("abort_quiet", {move_done, fall_valid}, 2'b00);
    end

    // random play against the model
    for (int i = 0; i < 70; i++) begin
      if (m_count == CELLS) start_new_game();
      do_move($urandom_range(0, 7), 0);
    end

    // fill the whole board
    start_new_game();
    for (int c = 0; c < COLS; c++)
      for (int i = 0; i < ROWS; i++) do_move(c, 0);
    check("full_state", {board_full, move_ready, turn}, 3'b100);

    // async reset while in COMMIT
    start_new_game();
    @(negedge clk);
    move_valid = 1'b1;
    move_col   = 3'd2;
    @(posedge clk); #1;
    move_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_commit", {fall_valid, fall_row, move_done}, {1'b1, 3'd0, 1'b0});
    rst_n = 1'b0;
    #1;
    check("async_reset", {turn, fall_valid, fall_col, fall_row, move_done, move_illegal, board_full}, '0);
    check("async_reset_panel", panel_flat, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    check("post_reset_quiet", {move_done, fall_valid, move_ready}, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
